fft_reorder_buf: RTL and testbench

- Parametrised ping-pong reorder buffer placed after the FFT_IFFT core. It converts bit-reversed FFT/IFFT output into natural order.
- The point count is selectable at run time, per frame, up to 2^MAX_STAGE.
- Adds valid/ready backpressure on both sides and a per-frame bypass mode. The fixed ORDERING option of the core has neither.
- Complex samples (real/imag) pass through unmodified.

---
 rtl/fft_reorder_buf.sv | 170 +++++++++++++++++
 tb/tb_fft_reorder_buf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buf.sv
// Ping-pong buffer that turns bit-reversed FFT/IFFT output into natural order, with per-frame size and bypass.
// Output appears 2 cycles after a frame's last input; valid/ready on both sides, input stalls while both banks are full.
module fft_reorder_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_STAGE  = 10,
  parameter int STG_W      = 4
) (
  input  logic                  iclk,
  input  logic                  rstn,
  input  logic [STG_W-1:0]      cfg_stage,
  input  logic                  cfg_bypass,
  input  logic                  ien,
  output logic                  iready,
  input  logic [DATA_WIDTH-1:0] iReal,
  input  logic [DATA_WIDTH-1:0] iImag,
  output logic                  oen,
  input  logic                  ordy,
  output logic [DATA_WIDTH-1:0] oReal,
  output logic [DATA_WIDTH-1:0] oImag,
  output logic                  ostart,
  output logic                  olast
);

  localparam int AW    = MAX_STAGE;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_WAIT} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  function automatic logic [STG_W-1:0] clamp_stage(input logic [STG_W-1:0] s);
    if (s == '0) return STG_W'(1);
    if (int'(s) > MAX_STAGE) return STG_W'(MAX_STAGE);
    return s;
  endfunction

  // N-1 for a given stage: the low `s` bits set.
  function automatic logic [AW-1:0] last_idx(input logic [STG_W-1:0] s);
    logic [AW-1:0] m;
    for (int i = 0; i < AW; i++) m[i] = (i < int'(s));
    return m;
  endfunction

  // Reverse the full address word, then shift the reversed low `s` bits back down.
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k, input logic [STG_W-1:0] s);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
    return r >> (AW - int'(s));
  endfunction

  logic [2*DATA_WIDTH-1:0] mem [2*DEPTH];

  wr_state_t        wr_state;
  logic             wr_bank;
  logic [AW-1:0]    wr_cnt;
  logic [STG_W-1:0] wr_stage;
  logic             wr_bypass;

  rd_state_t        rd_state;
  logic             rd_bank;
  logic [AW-1:0]    rd_cnt;

  logic [1:0]       full;
  logic [STG_W-1:0] bank_stage [2];

  logic             acc, first, cur_byp, wr_last, other_full_next;
  logic [STG_W-1:0] cur_stage;
  logic [AW-1:0]    wr_addr;
  logic             advance, rd_fire, rd_last, rel;

  assign iready    = !full[wr_bank];
  assign acc       = ien && iready;
  // Configuration is taken from the ports only on a frame's first sample.
  assign first     = (wr_cnt == '0);
  assign cur_stage = first ? clamp_stage(cfg_stage) : wr_stage;
  assign cur_byp   = first ? cfg_bypass : wr_bypass;
  assign wr_addr   = cur_byp ? wr_cnt : bitrev(wr_cnt, cur_stage);
  assign wr_last   = (wr_cnt == last_idx(cur_stage));

  assign advance   = !oen || ordy;
  assign rd_fire   = (rd_state == RD_RUN) && advance;
  assign rd_last   = (rd_cnt == last_idx(bank_stage[rd_bank]));
  assign rel       = rd_fire && rd_last;

  assign other_full_next = full[~wr_bank] && !(rel && (rd_bank == ~wr_bank));

  always_ff @(posedge iclk) begin
    if (acc) mem[{wr_bank, wr_addr}] <= {iReal, iImag};
  end

  // Bank status is shared by both sides; a release and a fill always target different banks.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      full          <= '0;
      bank_stage[0] <= STG_W'(1);
      bank_stage[1] <= STG_W'(1);
    end else begin
      if (rel) full[rd_bank] <= 1'b0;
      if (acc && wr_last) begin
        full[wr_bank]       <= 1'b1;
        bank_stage[wr_bank] <= cur_stage;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (!rstn) begin
      wr_state  <= WR_IDLE;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      wr_stage  <= STG_W'(1);
      wr_bypass <= 1'b0;
    end else if (acc) begin
      wr_stage  <= cur_stage;
      wr_bypass <= cur_byp;
      if (wr_last) begin
        wr_cnt   <= '0;
        wr_bank  <= ~wr_bank;
        wr_state <= other_full_next ? WR_WAIT : WR_IDLE;
      end else begin
        wr_cnt   <= wr_cnt + AW'(1);
        wr_state <= WR_FILL;
      end
    end else if (wr_state == WR_WAIT && rel && rd_bank == wr_bank) begin
      wr_state <= WR_IDLE;
    end
  end

  // The registered RAM read doubles as the output stage, so it only moves when downstream can take data.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
      oen      <= 1'b0;
      ostart   <= 1'b0;
      olast    <= 1'b0;
      oReal    <= '0;
      oImag    <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (full[rd_bank]) begin
            rd_state <= RD_RUN;
            rd_cnt   <= '0;
          end
        end
        RD_RUN: begin
          if (rd_fire) begin
            if (rd_last) begin
              rd_cnt  <= '0;
              rd_bank <= ~rd_bank;
              if (!full[~rd_bank]) rd_state <= RD_IDLE;
            end else begin
              rd_cnt <= rd_cnt + AW'(1);
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase

      if (advance) begin
        oen    <= rd_fire;
        ostart <= rd_fire && (rd_cnt == '0);
        olast  <= rd_fire && rd_last;
        if (rd_fire) {oReal, oImag} <= mem[{rd_bank, rd_cnt}];
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf: expected samples are queued as frames are driven and matched on output.
module tb_fft_reorder_buf;
  localparam int DW = 16;
  localparam int MS = 10;
  localparam int SW = 4;

  logic          iclk = 1'b0;
  logic          rstn;
  logic [SW-1:0] cfg_stage;
  logic          cfg_bypass;
  logic          ien;
  logic          iready;
  logic [DW-1:0] iReal, iImag;
  logic          oen;
  logic          ordy;
  logic [DW-1:0] oReal, oImag;
  logic          ostart, olast;

  fft_reorder_buf #(.DATA_WIDTH(DW), .MAX_STAGE(MS), .STG_W(SW)) dut (
    .iclk(iclk), .rstn(rstn), .cfg_stage(cfg_stage), .cfg_bypass(cfg_bypass),
    .ien(ien), .iready(iready), .iReal(iReal), .iImag(iImag),
    .oen(oen), .ordy(ordy), .oReal(oReal), .oImag(oImag),
    .ostart(ostart), .olast(olast)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          st;
    logic          la;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   acc_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int k, input int s);
    int r = 0;
    for (int i = 0; i < s; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // Output monitor: at each falling edge, predicts what transfers on the next rising edge.
  initial begin
    logic          hold_pend;
    logic [34:0]   snap;
    exp_t          e;
    hold_pend = 1'b0;
    snap = '0;
    forever begin
      @(negedge iclk);
      if (rstn && ien && iready) acc_cnt++;
      if (!rstn) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) chk("hold", 64'({oen, ostart, olast, oReal, oImag}), 64'(snap));
        hold_pend = oen && !ordy;
        snap = {oen, ostart, olast, oReal, oImag};
        if (oen && ordy) begin
          if (q.size() == 0) begin
            chk("out_when_empty", 64'(oen), 64'(0));
          end else begin
            e = q.pop_front();
            chk("out", 64'({oReal, oImag, ostart, olast}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 just after the sample was accepted.
  task automatic push(input int re, input int im);
    int t = 0;
    iReal = DW'(re);
    iImag = DW'(im);
    ien   = 1'b1;
    while (!iready && t < 2000) begin
      @(posedge iclk); #1;
      t++;
    end
    if (t >= 2000) chk("push_timeout", 64'(iready), 64'(1));
    @(posedge iclk); #1;
  endtask

  task automatic send_frame(input int cfg_s, input bit byp, input int base, input int toggle, input bit chk_rdy);
    int s;
    int n;
    int k;
    exp_t e;
    s = (cfg_s == 0) ? 1 : ((cfg_s > MS) ? MS : cfg_s);
    n = 1 << s;
    for (int j = 0; j < n; j++) begin
      k = byp ? j : brev(j, s);
      e.re = DW'(base + k);
      e.im = DW'(base + k + 100);
      e.st = (j == 0);
      e.la = (j == n - 1);
      q.push_back(e);
    end
    cfg_stage  = SW'(cfg_s);
    cfg_bypass = byp;
    for (int i = 0; i < n; i++) begin
      if (chk_rdy) chk("b2b_iready", 64'(iready), 64'(1));
      push(base + i, base + i + 100);
      if (i == 0 && toggle >= 0) cfg_stage = SW'(toggle);
    end
    ien = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(posedge iclk); #1;
      t++;
    end
    chk({tag, "_drained"}, 64'(q.size()), 64'(0));
    repeat (3) @(posedge iclk);
    #1;
    chk({tag, "_idle_oen"}, 64'(oen), 64'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    @(posedge iclk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    int acc0;
    int t;
    rstn = 1'b0; ien = 1'b0; ordy = 1'b1;
    cfg_stage = '0; cfg_bypass = 1'b0; iReal = '0; iImag = '0;
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_oen", 64'(oen), 64'(0));
    chk("rst_ostart", 64'(ostart), 64'(0));
    chk("rst_olast", 64'(olast), 64'(0));
    chk("rst_oReal", 64'(oReal), 64'(0));
    chk("rst_oImag", 64'(oImag), 64'(0));
    chk("rst_iready", 64'(iready), 64'(1));
    rstn = 1'b1;
    @(posedge iclk); #1;

    // Basic reorder with latency check
    send_frame(3, 1'b0, 0, -1, 1'b0);
    @(negedge iclk); chk("lat_edge0_oen", 64'(oen), 64'(0));
    @(negedge iclk); chk("lat_edge1_oen", 64'(oen), 64'(0));
    @(negedge iclk); chk("lat_edge2_oen", 64'(oen), 64'(1));
    @(posedge iclk); #1;
    drain("reorder");

    // Back-to-back mixed sizes
    fork
      begin
        send_frame(3, 1'b0, 20, -1, 1'b1);
        send_frame(2, 1'b0, 40, -1, 1'b1);
      end
      begin
        int run;
        int w;
        run = 0;
        w = 0;
        @(negedge iclk);
        while (!oen && w < 100) begin
          @(negedge iclk);
          w++;
        end
        for (int i = 0; i < 12; i++) begin
          if (oen) run++;
          @(negedge iclk);
        end
        chk("b2b_no_gap", 64'(run), 64'(12));
      end
    join
    @(posedge iclk); #1;
    drain("b2b");

    // Backpressure: three N=4 frames against a stalled sink
    ordy = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send_frame(2, 1'b0, 60, -1, 1'b0);
        send_frame(2, 1'b0, 70, -1, 1'b0);
        send_frame(2, 1'b0, 80, -1, 1'b0);
      end
      begin
        repeat (20) @(posedge iclk);
        #1;
        chk("bp_iready", 64'(iready), 64'(0));
        chk("bp_accepted", 64'(acc_cnt - acc0), 64'(8));
        chk("bp_oen", 64'(oen), 64'(1));
        chk("bp_ostart", 64'(ostart), 64'(1));
        ordy = 1'b1;
      end
    join
    drain("bp");

    // Bypass, mid-frame config change, then a normal frame
    send_frame(2, 1'b1, 90, -1, 1'b0);
    send_frame(2, 1'b0, 110, 3, 1'b0);
    send_frame(2, 1'b0, 120, -1, 1'b0);
    drain("bypass_cfg");

    // Stage clamping at both ends
    send_frame(0, 1'b0, 130, -1, 1'b0);
    send_frame(15, 1'b0, 0, -1, 1'b0);
    drain("clamp");

    // Reset mid-frame
    cfg_stage = SW'(3);
    cfg_bypass = 1'b0;
    for (int i = 0; i < 5; i++) push(500 + i, 600 + i);
    ien = 1'b0;
    do_reset();
    chk("rst_midframe_oen", 64'(oen), 64'(0));
    chk("rst_midframe_iready", 64'(iready), 64'(1));

    // Reset during a drain
    send_frame(3, 1'b0, 140, -1, 1'b0);
    t = 0;
    while (q.size() > 5 && t < 100) begin
      @(posedge iclk); #1;
      t++;
    end
    chk("rst_drain_started", 64'(q.size() <= 5), 64'(1));
    do_reset();
    chk("rst_drain_oen", 64'(oen), 64'(0));
    chk("rst_drain_iready", 64'(iready), 64'(1));
    repeat (5) @(posedge iclk);
    #1;
    chk("rst_no_stale_oen", 64'(oen), 64'(0));
    send_frame(3, 1'b0, 150, -1, 1'b0);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
